// File: rtl/debug_host_pkg.sv
// rtl/debug_host_pkg.sv - shared state encodings and frame constants for the debug host link
package debug_host_pkg;

    localparam int DEBUG_DATA_WIDTH = 8;
    localparam int DATA_BITS        = 8;
    localparam int FRAME_BITS       = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TX      = 2'd1,
        ST_RX_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RX_HUNT  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/debug_host_uart_rx.sv
// rtl/debug_host_uart_rx.sv - 8N1 receiver: synchronizer, mid-bit timing, shifter, stop check
module debug_host_uart_rx
    import debug_host_pkg::*;
#(
    parameter int BAUD_PERIOD = 868
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    input  logic                 arm_i,
    input  logic                 rxd_i,
    output logic                 start_edge_o,
    output logic                 byte_good_o,
    output logic                 byte_bad_o,
    output logic [DATA_BITS-1:0] byte_data_o
);

    localparam int CW = $clog2(BAUD_PERIOD + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_PERIOD / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_PERIOD - 1);
    localparam int BCW = $clog2(DATA_BITS);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 prev_q;
    rx_state_t            rx_state_q;
    logic [CW-1:0]        cnt_q;
    logic [BCW-1:0]       bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 stop_tick;

    // Falling edge of the synchronized line while hunting marks a candidate start bit
    assign start_edge_o = arm_i && (rx_state_q == RX_HUNT) && prev_q && !sync2_q;
    assign stop_tick    = arm_i && (rx_state_q == RX_STOP) && (cnt_q == FULL_M1);
    assign byte_good_o  = stop_tick && sync2_q;
    assign byte_bad_o   = stop_tick && !sync2_q;
    assign byte_data_o  = shift_q;

    // Synchronizer plus bit-timing state machine; disarming abandons any partial byte
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_state_q <= RX_HUNT;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (!arm_i) begin
                rx_state_q <= RX_HUNT;
                cnt_q      <= '0;
                bit_q      <= '0;
            end else begin
                case (rx_state_q)
                    RX_HUNT: begin
                        if (start_edge_o) begin
                            rx_state_q <= RX_START;
                            cnt_q      <= '0;
                        end
                    end
                    RX_START: begin
                        if (cnt_q == HALF_M1) begin
                            cnt_q      <= '0;
                            bit_q      <= '0;
                            // a start bit that is no longer low at mid-bit was a glitch
                            rx_state_q <= sync2_q ? RX_HUNT : RX_DATA;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    RX_DATA: begin
                        if (cnt_q == FULL_M1) begin
                            cnt_q   <= '0;
                            shift_q <= {sync2_q, shift_q[DATA_BITS-1:1]};
                            if (bit_q == BCW'(DATA_BITS - 1)) begin
                                rx_state_q <= RX_STOP;
                            end else begin
                                bit_q <= bit_q + BCW'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    RX_STOP: begin
                        if (cnt_q == FULL_M1) begin
                            cnt_q      <= '0;
                            rx_state_q <= RX_HUNT;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: rx_state_q <= RX_HUNT;
                endcase
            end
        end
    end

endmodule

// File: rtl/debug_host_link.sv
// rtl/debug_host_link.sv - command byte transmitter with counted, timed response reception
module debug_host_link
    import debug_host_pkg::*;
#(
    parameter int BAUD_PERIOD  = 868,
    parameter int RESP_TIMEOUT = 1000000
) (
    input  logic                        clk,
    input  logic                        sync_reset,
    input  logic                        cmd_valid,
    input  logic [DEBUG_DATA_WIDTH-1:0] cmd_data,
    input  logic [3:0]                  resp_len,
    output logic                        cmd_ready,
    output logic                        TXD,
    input  logic                        RXD,
    output logic                        resp_valid,
    output logic [7:0]                  resp_data,
    output logic                        done_pulse,
    output logic                        timeout_pulse,
    output logic                        frame_err,
    output logic                        busy
);

    localparam int BW  = $clog2(BAUD_PERIOD + 1);
    localparam int TW  = $clog2(RESP_TIMEOUT + 1);
    localparam int FBW = $clog2(FRAME_BITS + 1);
    localparam logic [BW-1:0]  BAUD_M1 = BW'(BAUD_PERIOD - 1);
    localparam logic [TW-1:0]  TO_M1   = TW'(RESP_TIMEOUT - 1);
    localparam logic [FBW-1:0] LAST_BIT = FBW'(FRAME_BITS - 1);

    state_t                state_q;
    logic                  rdy_en_q;
    logic                  txd_q;
    logic [DATA_BITS:0]    frame_q;
    logic [BW-1:0]         baud_q;
    logic [FBW-1:0]        bit_q;
    logic [3:0]            remain_q;
    logic [TW-1:0]         to_q;
    logic                  resp_valid_q;
    logic [7:0]            resp_data_q;
    logic                  done_q;
    logic                  timeout_q;
    logic                  frame_err_q;

    logic                  accept;
    logic                  rx_start;
    logic                  rx_good;
    logic                  rx_bad;
    logic [DATA_BITS-1:0]  rx_data;

    // rdy_en_q keeps cmd_ready low through the reset cycle while the state already reads IDLE
    assign cmd_ready     = rdy_en_q && (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign accept        = cmd_valid && cmd_ready;
    assign TXD           = txd_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign done_pulse    = done_q;
    assign timeout_pulse = timeout_q;
    assign frame_err     = frame_err_q;

    debug_host_uart_rx #(
        .BAUD_PERIOD (BAUD_PERIOD)
    ) u_rx (
        .clk          (clk),
        .sync_reset   (sync_reset),
        .arm_i        (state_q == ST_RX_WAIT),
        .rxd_i        (RXD),
        .start_edge_o (rx_start),
        .byte_good_o  (rx_good),
        .byte_bad_o   (rx_bad),
        .byte_data_o  (rx_data)
    );

    // Transaction FSM: transmit one framed byte, then collect resp_len bytes or time out
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q      <= ST_IDLE;
            rdy_en_q     <= 1'b0;
            txd_q        <= 1'b1;
            frame_q      <= '1;
            baud_q       <= '0;
            bit_q        <= '0;
            remain_q     <= '0;
            to_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rdy_en_q     <= 1'b1;
            resp_valid_q <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            if (rx_bad) begin
                frame_err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        // start bit goes out immediately; frame_q holds data then stop
                        frame_q     <= {1'b1, cmd_data};
                        txd_q       <= 1'b0;
                        baud_q      <= '0;
                        bit_q       <= '0;
                        remain_q    <= resp_len;
                        frame_err_q <= 1'b0;
                        state_q     <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (baud_q == BAUD_M1) begin
                        baud_q <= '0;
                        if (bit_q == LAST_BIT) begin
                            txd_q <= 1'b1;
                            to_q  <= '0;
                            if (remain_q == 4'd0) begin
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_RX_WAIT;
                            end
                        end else begin
                            bit_q   <= bit_q + FBW'(1);
                            txd_q   <= frame_q[0];
                            frame_q <= {1'b1, frame_q[DATA_BITS:1]};
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                ST_RX_WAIT: begin
                    if (rx_start) begin
                        to_q <= '0;
                    end else begin
                        to_q <= to_q + TW'(1);
                    end
                    if (rx_good) begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= rx_data;
                        if (remain_q != 4'd0) begin
                            remain_q <= remain_q - 4'd1;
                        end
                        if (remain_q == 4'd1) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end else if (!rx_start && (to_q == TO_M1)) begin
                        // a start edge on the expiry cycle takes priority over the timeout
                        timeout_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_host_link.sv
// tb/tb_debug_host_link.sv - scoreboard bench for debug_host_link with a UART target model
module tb_debug_host_link;

    localparam int BP = 16;
    localparam int TO = 400;
    localparam int K_RESP = 0;
    localparam int K_DONE = 1;
    localparam int K_TO   = 2;

    logic       clk = 1'b0;
    logic       sync_reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic [3:0] resp_len = 4'd0;
    logic       rxd = 1'b1;
    logic       cmd_ready, txd, resp_valid, done_pulse, timeout_pulse, frame_err, busy;
    logic [7:0] resp_data;

    typedef struct {
        int         kind;
        logic [7:0] data;
        bit         coinc;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc = 0;

    debug_host_link #(
        .BAUD_PERIOD  (BP),
        .RESP_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .sync_reset    (sync_reset),
        .cmd_valid     (cmd_valid),
        .cmd_data      (cmd_data),
        .resp_len      (resp_len),
        .cmd_ready     (cmd_ready),
        .TXD           (txd),
        .RXD           (rxd),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .done_pulse    (done_pulse),
        .timeout_pulse (timeout_pulse),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] data, input bit coinc, input int c);
        exp_t e;
        e.kind = kind; e.data = data; e.coinc = coinc; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic take(input int kind);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got pulse kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            e = sb.pop_front();
            check("sb_kind", kind, e.kind);
            if (kind == K_RESP) check("sb_resp_data", int'(resp_data), int'(e.data));
            if (kind == K_DONE) check("sb_done_with_resp", int'(resp_valid), int'(e.coinc));
            if (e.cyc >= 0) check("sb_cycle", cyc, e.cyc);
        end
    endtask

    // monitor: every output pulse must match the head of the expectation queue
    always @(negedge clk) begin
        if (!sync_reset) begin
            if (resp_valid)    take(K_RESP);
            if (done_pulse)    take(K_DONE);
            if (timeout_pulse) take(K_TO);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", int'(cmd_ready), 1);
    endtask

    task automatic send_cmd(input logic [7:0] d, input logic [3:0] l);
        @(negedge clk);
        wait_ready();
        cmd_valid = 1'b1; cmd_data = d; resp_len = l;
        @(posedge clk);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stopbit);
        logic [9:0] f;
        f = {stopbit, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd = f[k];
            repeat (BP) @(posedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic wait_timeout(input int limit);
        int found = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (timeout_pulse) begin
                found = 1;
                break;
            end
        end
        check("timeout_seen", found, 1);
    endtask

    initial begin
        logic [9:0] tx_exp;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", int'(txd), 1);
        check("rst_cmd_ready", int'(cmd_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_pulses", int'({resp_valid, done_pulse, timeout_pulse}), 0);
        @(negedge clk);
        sync_reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", int'(cmd_ready), 1);

        // RXD activity while idle must produce nothing
        send_byte(8'h55, 1'b1);

        // 0x5A with no response: bit pattern and done timing
        send_cmd(8'h5A, 4'd0);
        push(K_DONE, 8'h00, 1'b0, acc + 10 * BP);
        tx_exp = 10'b1010110100;
        repeat (BP / 2) @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            #1;
            check("tx_bit", int'(txd), int'(tx_exp[k]));
            if (k == 2) begin
                check("tx_cmd_ready_low", int'(cmd_ready), 0);
                check("tx_busy", int'(busy), 1);
            end
            repeat (BP) @(posedge clk);
        end
        #1;
        check("tx_idle_after", int'(busy), 0);

        // two response bytes, done with the second
        send_cmd(8'h01, 4'd2);
        push(K_RESP, 8'hA5, 1'b0, -1);
        push(K_RESP, 8'h3C, 1'b0, -1);
        push(K_DONE, 8'h00, 1'b1, -1);
        repeat (10 * BP + 10) @(posedge clk);
        send_byte(8'hA5, 1'b1);
        repeat (3) @(posedge clk);
        send_byte(8'h3C, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("resp2_idle", int'(busy), 0);

        // silent target: timeout 400 cycles after the stop bit
        send_cmd(8'h00, 4'd1);
        push(K_TO, 8'h00, 1'b0, acc + 10 * BP + TO);
        wait_timeout(700);
        @(negedge clk);
        check("timeout_busy_low", int'(busy), 0);

        // bad stop bit: discarded, sticky frame_err, then timeout
        send_cmd(8'h00, 4'd1);
        push(K_TO, 8'h00, 1'b0, -1);
        repeat (10 * BP + 10) @(posedge clk);
        send_byte(8'h77, 1'b0);
        #1;
        check("frame_err_set", int'(frame_err), 1);
        wait_timeout(600);
        check("frame_err_sticky", int'(frame_err), 1);

        // glitch then a valid byte; acceptance clears frame_err
        send_cmd(8'h00, 4'd1);
        check("frame_err_cleared", int'(frame_err), 0);
        push(K_RESP, 8'hC3, 1'b0, -1);
        push(K_DONE, 8'h00, 1'b1, -1);
        repeat (10 * BP + 10) @(posedge clk);
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        rxd = 1'b1;
        repeat (40) @(posedge clk);
        send_byte(8'hC3, 1'b1);
        repeat (20) @(posedge clk);

        // reset during bit 4 of transmit aborts the frame
        send_cmd(8'h00, 4'd1);
        repeat (4 * BP + BP / 2) @(posedge clk);
        #1;
        check("abort_txd_before", int'(txd), 0);
        @(negedge clk);
        sync_reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_txd", int'(txd), 1);
        check("abort_cmd_ready", int'(cmd_ready), 0);
        check("abort_busy", int'(busy), 0);
        @(negedge clk);
        sync_reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ready_after", int'(cmd_ready), 1);
        repeat (300) @(posedge clk);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/debug_host_link.md
DEBUG_HOST_LINK -- requirements
Module: debug_host_link

Interface
REQ-001 Parameter BAUD_PERIOD, default 868, clock cycles per UART bit.
REQ-002 Parameter RESP_TIMEOUT, default 1000000, idle cycles allowed between response bytes.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 sync_reset  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  command byte offered.
REQ-006 cmd_data  in  DEBUG_DATA_WIDTH (8)  command byte to transmit.
REQ-007 resp_len  in  4  response bytes expected after this command, 0..15; sampled with cmd_data.
REQ-008 cmd_ready  out  1  high only in IDLE.
REQ-009 TXD  out  1  serial out to target RXD; idle high.
REQ-010 RXD  in  1  serial in from target TXD; asynchronous.
REQ-011 resp_valid  out  1  one-cycle pulse per received response byte.
REQ-012 resp_data  out  8  received byte; valid when resp_valid is high.
REQ-013 done_pulse  out  1  one-cycle pulse when the transaction completes.
REQ-014 timeout_pulse  out  1  one-cycle pulse when the response times out.
REQ-015 frame_err  out  1  sticky; set on a bad stop bit.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 Line format SHALL be 8N1: start bit 0, then 8 data bits LSB first, then stop bit 1; each bit lasts BAUD_PERIOD cycles.
REQ-018 FSM states SHALL be IDLE, TX, RX_WAIT.
- IDLE: cmd_valid & cmd_ready captures cmd_data and resp_len, then goes to TX.
REQ-019 TX: TXD goes low on the cycle after acceptance; the stop bit ends exactly 10*BAUD_PERIOD cycles later.
- resp_len=0: done_pulse asserts on that cycle, then IDLE.
- Otherwise: go to RX_WAIT.
REQ-020 The receiver SHALL pass RXD through a 2-flop synchronizer.
- Start is a synchronized falling edge.
- Sample mid-bit at BAUD_PERIOD/2 (integer division), then every BAUD_PERIOD.
- Start bit not low at mid-bit = glitch; return to hunt, no output.
REQ-021 Receiver SHALL be armed only in RX_WAIT; RXD activity in IDLE/TX is ignored.
REQ-022 Stop bit sampled 1: resp_valid pulses with resp_data on the stop-sample cycle; remaining count decrements.
REQ-023 Stop bit sampled 0: byte discarded, frame_err set, remaining count unchanged.
REQ-024 Remaining count reaching 0 SHALL pulse done_pulse in the same cycle as the last resp_valid, then return to IDLE.
REQ-025 Timeout counter SHALL clear on entry to RX_WAIT and on every detected start edge.
- Reaching RESP_TIMEOUT-1 with no start edge: timeout_pulse, IDLE; any partial byte abandoned.
REQ-026 Start edge on the same cycle as timeout expiry: the start edge wins, no timeout.
REQ-027 frame_err SHALL clear only on sync_reset or on the next command acceptance.
REQ-028 cmd_valid while busy SHALL be ignored; no queuing.
REQ-029 Counters SHALL be sized $clog2(PARAM+1); resp_len counter is 4 bits, no wrap.

Reset
REQ-030 While sync_reset is high, outputs take these values on the next clock edge:
- TXD=1, cmd_ready=0
- resp_valid=0, done_pulse=0, timeout_pulse=0
- frame_err=0, busy=0
- state IDLE; all counters 0.
REQ-031 cmd_ready SHALL rise on the first cycle after sync_reset deasserts.
REQ-032 sync_reset mid-transmit SHALL abort the frame: TXD high next cycle, no done_pulse.

Structure
REQ-033 Package debug_host_pkg SHALL hold the FSM state encoding and bit-count constants (10 bits/frame, 8 data bits).
REQ-034 The receiver SHALL be sub-module debug_host_uart_rx (synchronizer, bit timing, shifter, stop check); the top holds the TX shifter, FSM and timeout counter.

Verification (bench BAUD_PERIOD=16, RESP_TIMEOUT=400)
REQ-035 cmd 0x5A, resp_len=0: TXD = 0,0,1,0,1,1,0,1,0,1 at 16 cycles per bit; done_pulse at cycle 161 after acceptance.
REQ-036 cmd 0x01, resp_len=2; target model returns 0xA5, 0x3C: two resp_valid pulses with those values, done_pulse coincident with the second.
REQ-037 resp_len=1, target silent: timeout_pulse 400 cycles after TX stop; busy low the next cycle.
REQ-038 resp_len=1, reply 0x77 with stop bit 0: no resp_valid, frame_err=1, then timeout_pulse.
REQ-039 4-cycle RXD low glitch in RX_WAIT: no byte output; a following valid 0xC3 is received correctly.
REQ-040 sync_reset asserted at bit 4 of TX: TXD=1 and cmd_ready=0 next cycle; cmd_ready=1 one cycle after release.
